// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - instruction memory req/ready fetch bus
interface instr_fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic            imem_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC owner and fetch stage feeding control_unit
// Alternates FETCH/EXEC; a misaligned next PC parks the unit in TRAP until reset.
module instr_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  instr_fetch_unit_if.master  imem,
  input  logic                branch,
  input  logic                zero,
  input  logic [XLEN-1:0]     imm,
  input  logic                stall,
  output logic [31:0]         instr,
  output logic [6:0]          opcode,
  output logic                instr_valid,
  output logic [XLEN-1:0]     pc,
  output logic [XLEN-1:0]     pc_plus4,
  output logic                misaligned
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    TRAP  = 2'd3
  } state_t;

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] next_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // Both adds wrap modulo 2^XLEN; the carry out is deliberately dropped.
  assign next_pc = (branch & zero) ? (pc_q + imm) : (pc_q + PC_STEP);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (imem.imem_ready) begin
          instr_d = imem.imem_rdata;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (!stall) begin
          if (next_pc[1:0] == 2'b00) begin
            pc_d    = next_pc;
            state_d = FETCH;
          end else begin
            state_d = TRAP;
          end
        end
      end
      TRAP:    state_d = TRAP;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode registered state only, so they cannot glitch.
  assign imem.imem_req  = (state_q == FETCH);
  assign imem.imem_addr = pc_q;
  assign instr_valid    = (state_q == EXEC);
  assign misaligned     = (state_q == TRAP);
  assign instr          = instr_q;
  assign opcode         = instr_q[6:0];
  assign pc             = pc_q;
  assign pc_plus4       = pc_q + PC_STEP;

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage that sits directly upstream of control_unit in the single-cycle core.
- Owns the PC and fetches each instruction from instruction memory over a req/ready handshake.
- Registers the fetched word and presents opcode/instruction fields to control_unit and the datapath for one execute window.
- Computes the next PC from the branch/zero outcome and traps on a misaligned target.

Parameters:
- XLEN, 32, width of PC, immediate and instruction-memory data/address.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  XLEN  fetch address; equals pc.
- imem_rdata  input  32  instruction word; valid in the cycle imem_ready=1.
- imem_ready  input  1  memory accepts the request and returns imem_rdata in the same cycle.
- branch  input  1  branch flag from control_unit.
- zero  input  1  ALU zero flag.
- imm  input  XLEN  sign-extended B-type byte offset from the immediate generator.
- stall  input  1  datapath not finished (data memory or UART busy); holds the execute window.
- instr  output  32  registered instruction word.
- opcode  output  7  instr[6:0], fed to control_unit.
- instr_valid  output  1  execute window active; the datapath ANDs reg write and MemWrite with this signal.
- pc  output  XLEN  current PC.
- pc_plus4  output  XLEN  pc + 4, used for writeback of link-type results.
- misaligned  output  1  sticky trap flag.

Behaviour:
- Reset (asynchronous, any state, including mid-fetch or mid-execute):
  - pc=RESET_PC, instr=0, state=IDLE.
  - imem_req=0, instr_valid=0, misaligned=0.
  - Reset release is synchronised to clk by the top level.
- FSM states: IDLE, FETCH, EXEC, TRAP.
- IDLE:
  - Outputs quiet for one cycle after reset release.
  - Always moves to FETCH.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - While imem_ready=0: stay in FETCH, holding req and addr stable.
  - On imem_ready=1: instr<=imem_rdata, go to EXEC.
  - Minimum fetch latency is 1 cycle.
- EXEC:
  - instr_valid=1; imem_req=0. imem_ready is ignored outside FETCH.
  - next_pc = (branch & zero) ? pc+imm : pc+4, computed modulo 2^XLEN (wrap, no carry out).
  - stall=1: remain in EXEC; pc and instr are held.
  - stall=0 and next_pc[1:0]==0: pc<=next_pc, go to FETCH.
  - stall=0 and next_pc[1:0]!=0: pc is unchanged, misaligned<=1, go to TRAP.
  - branch and zero are sampled only in the final cycle of EXEC (the cycle with stall=0).
- TRAP:
  - imem_req=0, instr_valid=0, misaligned=1.
  - Held until reset.
- Always-true relations:
  - opcode always equals instr[6:0], including outside EXEC, but is meaningful only while instr_valid=1.
  - pc_plus4 is combinational pc+4, also wrapping.
  - instr_valid is registered state decode, so it is glitch-free.
- Throughput: with zero-wait memory and stall=0, one instruction every 2 cycles (FETCH, EXEC).
- Corner cases:
  - pc=32'hFFFF_FFFC with no branch: next pc = 0.
  - imm=0 with branch taken: PC stays the same (self-loop), not a trap.

Test Plan:
- Reset with RESET_PC=0, zero-wait memory returning 32'h0000_0033 (R-type), branch=0, stall=0 -> instr_valid pulses on alternate cycles; opcode=7'h33; pc sequence 0,4,8,12.
- imem_ready held low for 3 cycles in FETCH at pc=8 -> imem_req=1 and imem_addr=8 stable for 4 cycles; instr latched on the ready cycle; EXEC follows next cycle.
- EXEC with opcode 7'h63, branch=1, zero=1, imm=-8 at pc=16 -> next fetch addr=8. Same with zero=0 -> next fetch addr=20.
- stall=1 for 5 cycles in EXEC at pc=4 -> instr_valid=1 and pc=4 for 6 cycles; then pc=8 and FETCH.
- Taken branch with imm=6 at pc=0 -> misaligned=1, state TRAP, imem_req=0 permanently, pc stays 0; rst_n low clears misaligned and pc=RESET_PC.
- rst_n asserted mid-FETCH, with imem_ready arriving in the same cycle -> outputs reset immediately; instr stays 0; restart via IDLE. Also pc=32'hFFFF_FFFC without branch -> next imem_addr=0.
